// File: rtl/mem_bus_pkg.sv
// Shared definitions for the memory-bus arbiter: state encoding, arbitration
// modes, bus field widths and the default timeout read data.
package mem_bus_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int STRB_W = 4;

  localparam int unsigned ARB_RR    = 0;
  localparam int unsigned ARB_FIXED = 1;

  // All-zero word decodes as an illegal instruction, so a timed-out fetch traps.
  localparam logic [DATA_W-1:0] DEFAULT_ERROR_RDATA = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } arb_state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way winner select: round-robin on a tie, or fixed priority to requester 0
// when mode is high.
module rr_arb2 (
  input  logic [1:0] valid,
  input  logic       last_grant,
  input  logic       mode,
  output logic       winner,
  output logic       any_valid
);

  always_comb begin
    any_valid = |valid;
    winner    = 1'b0;
    if (valid == 2'b10) begin
      winner = 1'b1;
    end else if (valid == 2'b11) begin
      winner = mode ? 1'b0 : ~last_grant;
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares the system memory bus between two valid/ready requesters: registers the
// granted request, forwards it downstream and returns the response to the winner.
module mem_bus_arbiter
  import mem_bus_pkg::*;
#(
  parameter int unsigned       ARB_MODE       = ARB_RR,
  parameter int unsigned       TIMEOUT_CYCLES = 255,
  parameter logic [DATA_W-1:0] ERROR_RDATA    = DEFAULT_ERROR_RDATA
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              m0_valid,
  input  logic              m0_instr,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  input  logic [STRB_W-1:0] m0_wstrb,
  output logic              m0_ready,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_valid,
  input  logic              m1_instr,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  input  logic [STRB_W-1:0] m1_wstrb,
  output logic              m1_ready,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              s_valid,
  output logic              s_instr,
  output logic [ADDR_W-1:0] s_addr,
  output logic [DATA_W-1:0] s_wdata,
  output logic [STRB_W-1:0] s_wstrb,
  input  logic              s_ready,
  input  logic [DATA_W-1:0] s_rdata,
  output logic              grant,
  output logic              timeout_event
);

  localparam logic       ARB_SEL_FIXED = (ARB_MODE == ARB_FIXED);
  localparam logic       WDOG_EN       = (TIMEOUT_CYCLES != 0);
  localparam logic [7:0] WDOG_LAST     = 8'(TIMEOUT_CYCLES - 1);

  arb_state_t        state;
  logic              last_grant;
  logic [7:0]        wait_cnt;
  logic              winner;
  logic              any_valid;
  logic              expire;
  logic              done;
  logic [DATA_W-1:0] resp_data;

  rr_arb2 u_arb (
    .valid      ({m1_valid, m0_valid}),
    .last_grant (last_grant),
    .mode       (ARB_SEL_FIXED),
    .winner     (winner),
    .any_valid  (any_valid)
  );

  // s_ready takes precedence, so a response landing on the expiry cycle is kept.
  assign expire    = WDOG_EN && (wait_cnt == WDOG_LAST) && !s_ready;
  assign done      = s_ready || expire;
  assign resp_data = s_ready ? s_rdata : ERROR_RDATA;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state         <= IDLE;
      last_grant    <= 1'b1;
      grant         <= 1'b0;
      wait_cnt      <= 8'd0;
      s_valid       <= 1'b0;
      s_instr       <= 1'b0;
      s_addr        <= '0;
      s_wdata       <= '0;
      s_wstrb       <= '0;
      m0_ready      <= 1'b0;
      m1_ready      <= 1'b0;
      m0_rdata      <= '0;
      m1_rdata      <= '0;
      timeout_event <= 1'b0;
    end else begin
      m0_ready      <= 1'b0;
      m1_ready      <= 1'b0;
      timeout_event <= 1'b0;
      case (state)
        IDLE: begin
          if (any_valid) begin
            s_instr    <= winner ? m1_instr : m0_instr;
            s_addr     <= winner ? m1_addr  : m0_addr;
            s_wdata    <= winner ? m1_wdata : m0_wdata;
            s_wstrb    <= winner ? m1_wstrb : m0_wstrb;
            grant      <= winner;
            last_grant <= winner;
            wait_cnt   <= 8'd0;
            s_valid    <= 1'b1;
            state      <= BUSY;
          end
        end
        BUSY: begin
          if (done) begin
            if (grant) m1_rdata <= resp_data;
            else       m0_rdata <= resp_data;
            m0_ready      <= ~grant;
            m1_ready      <= grant;
            timeout_event <= expire;
            s_valid       <= 1'b0;
            state         <= RESP;
          end else if (wait_cnt != 8'hFF) begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench: a round-robin and a fixed-priority arbiter share one
// stimulus stream and are compared every cycle against a transaction-level model.
module tb_mem_bus_arbiter;

  localparam int          TO  = 4;
  localparam logic [31:0] ERR = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        m0_valid, m0_instr, m1_valid, m1_instr;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic [3:0]  m0_wstrb, m1_wstrb;
  logic        s_ready;
  logic [31:0] s_rdata;

  logic        d_m0_ready[2], d_m1_ready[2], d_s_valid[2], d_s_instr[2];
  logic        d_grant[2], d_timeout[2];
  logic [31:0] d_m0_rdata[2], d_m1_rdata[2], d_s_addr[2], d_s_wdata[2];
  logic [3:0]  d_s_wstrb[2];

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  // Instance 0 is round-robin, instance 1 is fixed priority.
  for (genvar g = 0; g < 2; g++) begin : g_dut
    mem_bus_arbiter #(
      .ARB_MODE       (g),
      .TIMEOUT_CYCLES (TO),
      .ERROR_RDATA    (ERR)
    ) u_dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .m0_valid      (m0_valid),
      .m0_instr      (m0_instr),
      .m0_addr       (m0_addr),
      .m0_wdata      (m0_wdata),
      .m0_wstrb      (m0_wstrb),
      .m0_ready      (d_m0_ready[g]),
      .m0_rdata      (d_m0_rdata[g]),
      .m1_valid      (m1_valid),
      .m1_instr      (m1_instr),
      .m1_addr       (m1_addr),
      .m1_wdata      (m1_wdata),
      .m1_wstrb      (m1_wstrb),
      .m1_ready      (d_m1_ready[g]),
      .m1_rdata      (d_m1_rdata[g]),
      .s_valid       (d_s_valid[g]),
      .s_instr       (d_s_instr[g]),
      .s_addr        (d_s_addr[g]),
      .s_wdata       (d_s_wdata[g]),
      .s_wstrb       (d_s_wstrb[g]),
      .s_ready       (s_ready),
      .s_rdata       (s_rdata),
      .grant         (d_grant[g]),
      .timeout_event (d_timeout[g])
    );
  end

  // Transaction-level model: one outstanding access, its wait length, and a
  // response cycle; arbitration follows the tie rules for each mode.
  bit          mdl_on = 1'b0;
  bit          mdl_active[2], mdl_resp[2], mdl_timeout[2], mdl_who[2], mdl_last[2];
  int          mdl_busy[2];
  bit          mdl_instr[2];
  logic [31:0] mdl_addr[2], mdl_wdata[2];
  logic [3:0]  mdl_wstrb[2];
  logic [31:0] mdl_rdata[2][2];

  function automatic bit pick(input bit v0, input bit v1, input bit fixed_prio, input bit last);
    if (v0 && v1) return fixed_prio ? 1'b0 : !last;
    return v1 && !v0;
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!reset_n) begin
        mdl_active[i]   <= 1'b0;
        mdl_resp[i]     <= 1'b0;
        mdl_timeout[i]  <= 1'b0;
        mdl_who[i]      <= 1'b0;
        mdl_last[i]     <= 1'b1;
        mdl_busy[i]     <= 0;
        mdl_instr[i]    <= 1'b0;
        mdl_addr[i]     <= '0;
        mdl_wdata[i]    <= '0;
        mdl_wstrb[i]    <= '0;
        mdl_rdata[i][0] <= '0;
        mdl_rdata[i][1] <= '0;
      end else if (mdl_resp[i]) begin
        mdl_resp[i]    <= 1'b0;
        mdl_timeout[i] <= 1'b0;
      end else if (mdl_active[i]) begin
        if (s_ready || mdl_busy[i] == TO) begin
          mdl_rdata[i][mdl_who[i]] <= s_ready ? s_rdata : ERR;
          mdl_timeout[i] <= !s_ready;
          mdl_active[i]  <= 1'b0;
          mdl_resp[i]    <= 1'b1;
        end else begin
          mdl_busy[i] <= mdl_busy[i] + 1;
        end
      end else if (m0_valid || m1_valid) begin
        mdl_who[i]    <= pick(m0_valid, m1_valid, i == 1, mdl_last[i]);
        mdl_last[i]   <= pick(m0_valid, m1_valid, i == 1, mdl_last[i]);
        mdl_instr[i]  <= pick(m0_valid, m1_valid, i == 1, mdl_last[i]) ? m1_instr : m0_instr;
        mdl_addr[i]   <= pick(m0_valid, m1_valid, i == 1, mdl_last[i]) ? m1_addr  : m0_addr;
        mdl_wdata[i]  <= pick(m0_valid, m1_valid, i == 1, mdl_last[i]) ? m1_wdata : m0_wdata;
        mdl_wstrb[i]  <= pick(m0_valid, m1_valid, i == 1, mdl_last[i]) ? m1_wstrb : m0_wstrb;
        mdl_active[i] <= 1'b1;
        mdl_busy[i]   <= 1;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s at %0t: got 0x%08h, expected 0x%08h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mdl_on) begin
      for (int i = 0; i < 2; i++) begin
        checkOutput($sformatf("u%0d s_valid", i), 32'(d_s_valid[i]), 32'(mdl_active[i]));
        checkOutput($sformatf("u%0d grant", i), 32'(d_grant[i]), 32'(mdl_who[i]));
        checkOutput($sformatf("u%0d m0_ready", i), 32'(d_m0_ready[i]), 32'(mdl_resp[i] && !mdl_who[i]));
        checkOutput($sformatf("u%0d m1_ready", i), 32'(d_m1_ready[i]), 32'(mdl_resp[i] && mdl_who[i]));
        checkOutput($sformatf("u%0d timeout_event", i), 32'(d_timeout[i]), 32'(mdl_resp[i] && mdl_timeout[i]));
        checkOutput($sformatf("u%0d m0_rdata", i), d_m0_rdata[i], mdl_rdata[i][0]);
        checkOutput($sformatf("u%0d m1_rdata", i), d_m1_rdata[i], mdl_rdata[i][1]);
        if (mdl_active[i]) begin
          checkOutput($sformatf("u%0d s_instr", i), 32'(d_s_instr[i]), 32'(mdl_instr[i]));
          checkOutput($sformatf("u%0d s_addr", i), d_s_addr[i], mdl_addr[i]);
          checkOutput($sformatf("u%0d s_wdata", i), d_s_wdata[i], mdl_wdata[i]);
          checkOutput($sformatf("u%0d s_wstrb", i), 32'(d_s_wstrb[i]), 32'(mdl_wstrb[i]));
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic idleInputs();
    m0_valid = 1'b0; m0_instr = 1'b0; m0_addr = '0; m0_wdata = '0; m0_wstrb = '0;
    m1_valid = 1'b0; m1_instr = 1'b0; m1_addr = '0; m1_wdata = '0; m1_wstrb = '0;
    s_ready  = 1'b0; s_rdata  = '0;
  endtask

  task automatic applyStimulus();
    reset_n  = ($urandom_range(0, 199) != 0);
    m0_valid = ($urandom_range(0, 1) == 1);
    m0_instr = ($urandom_range(0, 1) == 1);
    m0_addr  = $urandom();
    m0_wdata = $urandom();
    m0_wstrb = 4'($urandom_range(0, 15));
    m1_valid = ($urandom_range(0, 1) == 1);
    m1_instr = ($urandom_range(0, 1) == 1);
    m1_addr  = $urandom();
    m1_wdata = $urandom();
    m1_wstrb = 4'($urandom_range(0, 15));
    s_ready  = ($urandom_range(0, 9) < 3);
    s_rdata  = $urandom();
  endtask

  int n_valid;
  int to_at;
  int n_grant;
  int rdy_cnt[4];

  initial begin
    idleInputs();
    reset_n = 1'b0;
    repeat (2) tick();
    mdl_on = 1'b1;
    checkOutput("reset s_valid", 32'(d_s_valid[0]), 32'd0);
    checkOutput("reset grant", 32'(d_grant[0]), 32'd0);
    checkOutput("reset m0_rdata", d_m0_rdata[0], 32'd0);
    checkOutput("reset s_addr", d_s_addr[0], 32'd0);
    reset_n = 1'b1;

    // Single m0 read answered on the first BUSY cycle.
    m0_valid = 1'b1; m0_addr = 32'h4000_0010;
    tick();
    checkOutput("read s_valid", 32'(d_s_valid[0]), 32'd1);
    checkOutput("read s_addr", d_s_addr[0], 32'h4000_0010);
    m0_valid = 1'b0; s_ready = 1'b1; s_rdata = 32'hCAFE_F00D;
    tick();
    checkOutput("read m0_ready", 32'(d_m0_ready[0]), 32'd1);
    checkOutput("read m0_rdata", d_m0_rdata[0], 32'hCAFE_F00D);
    checkOutput("read m1_ready", 32'(d_m1_ready[0]), 32'd0);
    checkOutput("model read rdata", mdl_rdata[0][0], 32'hCAFE_F00D);
    s_ready = 1'b0;
    tick();

    // m1 write that the target never acknowledges.
    m1_valid = 1'b1; m1_addr = 32'h2000_0040; m1_wdata = 32'hDEAD_BEEF; m1_wstrb = 4'hF;
    tick();
    m1_valid = 1'b0;
    n_valid = 0;
    to_at = -1;
    for (int c = 1; c <= 8; c++) begin
      if (d_s_valid[0]) n_valid++;
      if (c == 1) checkOutput("timeout s_wdata", d_s_wdata[0], 32'hDEAD_BEEF);
      if (d_timeout[0]) begin
        to_at = c;
        checkOutput("timeout m1_ready", 32'(d_m1_ready[0]), 32'd1);
        checkOutput("timeout m1_rdata", d_m1_rdata[0], 32'h0);
      end
      tick();
    end
    checkOutput("timeout s_valid cycles", 32'(n_valid), 32'd4);
    checkOutput("timeout pulse cycle", 32'(to_at), 32'd5);

    // s_ready lands exactly on the expiry cycle.
    m0_valid = 1'b1; m0_instr = 1'b1; m0_addr = 32'h0000_0100;
    tick();
    m0_valid = 1'b0; m0_instr = 1'b0;
    repeat (3) tick();
    s_ready = 1'b1; s_rdata = 32'h1234_5678;
    tick();
    checkOutput("expiry m0_ready", 32'(d_m0_ready[0]), 32'd1);
    checkOutput("expiry m0_rdata", d_m0_rdata[0], 32'h1234_5678);
    checkOutput("expiry timeout_event", 32'(d_timeout[0]), 32'd0);
    s_ready = 1'b0;
    tick();

    // Both requesters held valid; last grant was m0, so round-robin starts with m1.
    m0_valid = 1'b1; m1_valid = 1'b1; m0_addr = 32'h0000_0A00; m1_addr = 32'h0000_0B00;
    s_ready = 1'b1; s_rdata = 32'h0BAD_CAFE;
    n_grant = 0;
    for (int k = 0; k < 4; k++) rdy_cnt[k] = 0;
    for (int c = 1; c <= 12; c++) begin
      if (d_s_valid[0]) begin
        checkOutput($sformatf("rr grant %0d", n_grant), 32'(d_grant[0]), (n_grant % 2 == 0) ? 32'd1 : 32'd0);
        n_grant++;
      end
      if (d_s_valid[1]) checkOutput("fixed grant", 32'(d_grant[1]), 32'd0);
      if (d_m0_ready[0]) rdy_cnt[0]++;
      if (d_m1_ready[0]) rdy_cnt[1]++;
      if (d_m0_ready[1]) rdy_cnt[2]++;
      if (d_m1_ready[1]) rdy_cnt[3]++;
      tick();
    end
    checkOutput("rr grant count", 32'(n_grant), 32'd4);
    checkOutput("rr m0 readies", 32'(rdy_cnt[0]), 32'd2);
    checkOutput("rr m1 readies", 32'(rdy_cnt[1]), 32'd2);
    checkOutput("fixed m0 readies", 32'(rdy_cnt[2]), 32'd4);
    checkOutput("fixed m1 readies", 32'(rdy_cnt[3]), 32'd0);
    idleInputs();
    repeat (3) tick();

    // Reset while BUSY aborts the access; first tie afterwards goes to m0.
    m0_valid = 1'b1; m0_addr = 32'h0000_0055;
    tick();
    checkOutput("abort s_valid before", 32'(d_s_valid[0]), 32'd1);
    reset_n = 1'b0; m0_valid = 1'b0;
    tick();
    checkOutput("abort s_valid", 32'(d_s_valid[0]), 32'd0);
    checkOutput("abort m0_ready", 32'(d_m0_ready[0]), 32'd0);
    checkOutput("abort m0_rdata", d_m0_rdata[0], 32'd0);
    checkOutput("abort s_addr", d_s_addr[0], 32'd0);
    reset_n = 1'b1; m0_valid = 1'b1; m1_valid = 1'b1;
    tick();
    checkOutput("post-reset rr grant", 32'(d_grant[0]), 32'd0);
    checkOutput("post-reset fixed grant", 32'(d_grant[1]), 32'd0);
    idleInputs();
    s_ready = 1'b1;
    tick();
    checkOutput("post-reset m0_ready", 32'(d_m0_ready[0]), 32'd1);
    s_ready = 1'b0;
    tick();

    for (int n = 0; n < 3000; n++) begin
      applyStimulus();
      tick();
    end
    reset_n = 1'b1;
    idleInputs();
    repeat (8) tick();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
